// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator self-test: FSM state encoding and
// default sizing constants.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_ERR_CNT_W     = 9;

endpackage

// File: rtl/cmp_ref_model.sv
// Golden reference for an unsigned magnitude comparator: produces the flags
// a correct comparator must return for operands a and b.
module cmp_ref_model #(
    parameter int WIDTH = comparator_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/comparator_bist.sv
// Exhaustive self-test sequencer for a magnitude comparator: sweeps every
// operand pair, waits a settle time, and checks the three result flags.
module comparator_bist
    import comparator_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int ERR_CNT_W     = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic                 agt_b,
    input  logic                 alt_b,
    input  logic                 aeq_b,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 fail_valid,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b
);

    localparam int VW = 2 * WIDTH;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);

    state_t                 state;
    logic [VW-1:0]          vec;
    logic [SW-1:0]          settle;
    logic                   exp_gt;
    logic                   exp_lt;
    logic                   exp_eq;
    logic                   vec_fail;
    logic [ERR_CNT_W-1:0]   err_next;

    assign a_out = vec[VW-1:WIDTH];
    assign b_out = vec[WIDTH-1:0];

    cmp_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a  (vec[VW-1:WIDTH]),
        .b  (vec[WIDTH-1:0]),
        .gt (exp_gt),
        .lt (exp_lt),
        .eq (exp_eq)
    );

    // Any flag mismatch fails the vector, which also catches non-one-hot results.
    assign vec_fail = (agt_b != exp_gt) || (alt_b != exp_lt) || (aeq_b != exp_eq);

    always_comb begin
        err_next = err_count;
        if (vec_fail && (err_count != {ERR_CNT_W{1'b1}}))
            err_next = err_count + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            settle     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= DRIVE;
                        vec        <= '0;
                        settle     <= SETTLE_INIT;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                    end
                end
                DRIVE: begin
                    if (settle != '0)
                        settle <= settle - SW'(1);
                    else
                        state <= CHECK;
                end
                CHECK: begin
                    err_count <= err_next;
                    if (vec_fail && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= vec[VW-1:WIDTH];
                        fail_b     <= vec[WIDTH-1:0];
                    end
                    // Operands advance only here, after the flags were sampled.
                    if (vec == {VW{1'b1}}) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        state  <= DRIVE;
                        vec    <= vec + VW'(1);
                        settle <= SETTLE_INIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_bist.sv
// Self-checking bench: a behavioural comparator with injectable faults is
// swept by the BIST; results are checked against hand-computed values.
module tb_comparator_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a_out, b_out;
    logic       agt_b, alt_b, aeq_b;
    logic       busy, done, pass, fail_valid;
    logic [8:0] err_count;
    logic [3:0] fail_a, fail_b;

    logic [3:0] a2, b2;
    logic       busy2, done2, pass2, fail_valid2;
    logic [3:0] err_count2;
    logic [3:0] fail_a2, fail_b2;

    int fault_mode;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // fault 0 good, 1 AgtB stuck-0, 2 AeqB stuck-1, 3 AltB stuck-1, 4 all flags 0
    always_comb begin
        agt_b = (a_out > b_out);
        alt_b = (a_out < b_out);
        aeq_b = (a_out == b_out);
        case (fault_mode)
            1: agt_b = 1'b0;
            2: aeq_b = 1'b1;
            3: alt_b = 1'b1;
            4: begin agt_b = 1'b0; alt_b = 1'b0; aeq_b = 1'b0; end
            default: ;
        endcase
    end

    comparator_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a_out), .b_out(b_out),
        .agt_b(agt_b), .alt_b(alt_b), .aeq_b(aeq_b),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b)
    );

    // Narrow counter instance fed a comparator whose AeqB is stuck at 1.
    comparator_bist #(.ERR_CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a2), .b_out(b2),
        .agt_b(a2 > b2), .alt_b(a2 < b2), .aeq_b(1'b1),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .fail_valid(fail_valid2), .fail_a(fail_a2), .fail_b(fail_b2)
    );

    typedef struct {
        int fault;
        int err;
        int pass;
        int fv;
        int fa;
        int fb;
    } rec_t;

    rec_t tbl[5];

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Pulse start for exactly one rising edge; returns at the negedge after it.
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; optional start poke mid-run.
    task automatic runSweep(input int poke_at, output int cycles);
        cycles = 0;
        while (cycles < 2000) begin
            @(negedge clk);
            cycles++;
            start = (cycles == poke_at);
            if (done) break;
        end
        start = 1'b0;
    endtask

    int cyc;

    initial begin
        tbl[0] = '{fault:0, err:0,   pass:1, fv:0, fa:0, fb:0};
        tbl[1] = '{fault:1, err:120, pass:0, fv:1, fa:1, fb:0};
        tbl[2] = '{fault:2, err:240, pass:0, fv:1, fa:0, fb:1};
        tbl[3] = '{fault:3, err:136, pass:0, fv:1, fa:0, fb:0};
        tbl[4] = '{fault:4, err:256, pass:0, fv:1, fa:0, fb:0};

        fault_mode = 0;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_pass", pass, 0);
        checkOutput("reset_err", err_count, 0);
        checkOutput("reset_ab", {a_out, b_out}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            fault_mode = tbl[i].fault;
            applyStimulus();
            checkOutput("busy_on_accept", busy, 1);
            runSweep(-1, cyc);
            checkOutput("sweep_cycles", cyc, 768);
            checkOutput("done", done, 1);
            checkOutput("busy_at_done", busy, 0);
            checkOutput("err_count", err_count, tbl[i].err);
            checkOutput("pass", pass, tbl[i].pass);
            checkOutput("fail_valid", fail_valid, tbl[i].fv);
            checkOutput("fail_a", fail_a, tbl[i].fa);
            checkOutput("fail_b", fail_b, tbl[i].fb);
            checkOutput("last_vec", {a_out, b_out}, 255);
        end

        checkOutput("sat_done", done2, 1);
        checkOutput("sat_err", err_count2, 15);
        checkOutput("sat_pass", pass2, 0);
        checkOutput("sat_fail_b", fail_b2, 1);

        // Start in DONE re-clears results and runs a fresh sweep.
        fault_mode = 0;
        applyStimulus();
        checkOutput("restart_done_low", done, 0);
        checkOutput("restart_err_clr", err_count, 0);
        checkOutput("restart_fv_clr", fail_valid, 0);
        runSweep(300, cyc);
        checkOutput("poke_cycles", cyc, 768);
        checkOutput("poke_pass", pass, 1);

        // Asynchronous reset 100 cycles into a sweep.
        fault_mode = 2;
        applyStimulus();
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_busy", busy, 0);
        checkOutput("async_err", err_count, 0);
        checkOutput("async_fv", fail_valid, 0);
        checkOutput("async_ab", {a_out, b_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fault_mode = 0;
        applyStimulus();
        runSweep(-1, cyc);
        checkOutput("post_reset_cycles", cyc, 768);
        checkOutput("post_reset_pass", pass, 1);
        checkOutput("post_reset_err", err_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
